// File: rtl/m68k_bus_bridge.sv
// 68000 bus to single-outstanding req/ack memory port bridge, sampled in the clk domain.
// Handles autovectored IACK, bus-error timeout, DMA hold-off and abort/drain of a pending request.
module m68k_bus_bridge #(
    parameter int ADDR_W  = 24,
    parameter int TIMEOUT = 255,
    parameter bit AUTOVEC = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              dma_hold,
    input  logic              cpu_as_n,
    input  logic              cpu_uds_n,
    input  logic              cpu_lds_n,
    input  logic              cpu_rw_n,
    input  logic [2:0]        cpu_fc,
    input  logic [ADDR_W-2:0] cpu_addr,
    input  logic [15:0]       cpu_dout,
    output logic [15:0]       cpu_din,
    output logic              cpu_dtack_n,
    output logic              cpu_vpa_n,
    output logic              cpu_berr_n,
    output logic              mem_req,
    output logic              mem_we,
    output logic [1:0]        mem_be,
    output logic [ADDR_W-2:0] mem_addr,
    output logic [15:0]       mem_wdata,
    input  logic              mem_ack,
    input  logic              mem_err,
    input  logic [15:0]       mem_rdata
);

    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] LAST_CNT = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_DONE,
        S_BERR,
        S_IACK,
        S_DRAIN
    } state_t;

    state_t             r_state;
    logic [CW-1:0]      r_cnt;
    logic [15:0]        r_din;
    logic               r_dtack_n;
    logic               r_vpa_n;
    logic               r_berr_n;
    logic               r_req;
    logic               r_we;
    logic [1:0]         r_be;
    logic [ADDR_W-2:0]  r_addr;
    logic [15:0]        r_wdata;

    logic w_start;
    logic w_iack;
    logic w_timeout;

    assign w_start   = ~cpu_as_n & (~cpu_uds_n | ~cpu_lds_n) & ~dma_hold;
    assign w_iack    = (cpu_fc == 3'b111) && AUTOVEC;
    assign w_timeout = (TIMEOUT != 0) && (r_cnt == LAST_CNT);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_din     <= '0;
            r_dtack_n <= 1'b1;
            r_vpa_n   <= 1'b1;
            r_berr_n  <= 1'b1;
            r_req     <= 1'b0;
            r_we      <= 1'b0;
            r_be      <= '0;
            r_addr    <= '0;
            r_wdata   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        if (w_iack) begin
                            r_vpa_n <= 1'b0;
                            r_state <= S_IACK;
                        end else begin
                            r_addr  <= cpu_addr;
                            r_we    <= ~cpu_rw_n;
                            r_be    <= ~{cpu_uds_n, cpu_lds_n};
                            r_wdata <= cpu_dout;
                            r_req   <= 1'b1;
                            r_cnt   <= '0;
                            r_state <= S_REQ;
                        end
                    end
                end
                S_REQ: begin
                    // error outranks ack, and a completion outranks a CPU abort
                    if (mem_err) begin
                        r_req    <= 1'b0;
                        r_berr_n <= 1'b0;
                        r_state  <= S_BERR;
                    end else if (mem_ack) begin
                        r_req     <= 1'b0;
                        r_dtack_n <= 1'b0;
                        if (!r_we) begin
                            r_din <= mem_rdata;
                        end
                        r_state <= S_DONE;
                    end else if (cpu_as_n) begin
                        r_state <= S_DRAIN;
                    end else if (w_timeout) begin
                        r_req    <= 1'b0;
                        r_berr_n <= 1'b0;
                        r_state  <= S_BERR;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    if (cpu_as_n) begin
                        r_dtack_n <= 1'b1;
                        r_state   <= S_IDLE;
                    end
                end
                S_BERR: begin
                    if (cpu_as_n) begin
                        r_berr_n <= 1'b1;
                        r_state  <= S_IDLE;
                    end
                end
                S_IACK: begin
                    if (cpu_as_n) begin
                        r_vpa_n <= 1'b1;
                        r_state <= S_IDLE;
                    end
                end
                S_DRAIN: begin
                    // memory still owes a completion; swallow it silently
                    if (mem_ack || mem_err) begin
                        r_req   <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign cpu_din     = r_din;
    assign cpu_dtack_n = r_dtack_n;
    assign cpu_vpa_n   = r_vpa_n;
    assign cpu_berr_n  = r_berr_n;
    assign mem_req     = r_req;
    assign mem_we      = r_we;
    assign mem_be      = r_be;
    assign mem_addr    = r_addr;
    assign mem_wdata   = r_wdata;

endmodule

// File: tb/tb_m68k_bus_bridge.sv
// Bench for m68k_bus_bridge: table vectors, hand-written corner sequences and random transactions
// checked against a transaction-level model of the bridge's rules.
module tb_m68k_bus_bridge;

    localparam int TO_A = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        dma_hold;
    logic        cpu_as_n, cpu_uds_n, cpu_lds_n, cpu_rw_n;
    logic [2:0]  cpu_fc;
    logic [22:0] cpu_addr;
    logic [15:0] cpu_dout;
    logic        mem_ack, mem_err;
    logic [15:0] mem_rdata;

    logic [15:0] a_din, b_din;
    logic        a_dtack_n, a_vpa_n, a_berr_n, a_req, a_we;
    logic        b_dtack_n, b_vpa_n, b_berr_n, b_req, b_we;
    logic [1:0]  a_be, b_be;
    logic [22:0] a_addr, b_addr;
    logic [15:0] a_wdata, b_wdata;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    m68k_bus_bridge #(.ADDR_W(24), .TIMEOUT(TO_A), .AUTOVEC(1'b1)) dut_a (
        .clk(clk), .reset(reset), .dma_hold(dma_hold),
        .cpu_as_n(cpu_as_n), .cpu_uds_n(cpu_uds_n), .cpu_lds_n(cpu_lds_n),
        .cpu_rw_n(cpu_rw_n), .cpu_fc(cpu_fc), .cpu_addr(cpu_addr), .cpu_dout(cpu_dout),
        .cpu_din(a_din), .cpu_dtack_n(a_dtack_n), .cpu_vpa_n(a_vpa_n), .cpu_berr_n(a_berr_n),
        .mem_req(a_req), .mem_we(a_we), .mem_be(a_be), .mem_addr(a_addr), .mem_wdata(a_wdata),
        .mem_ack(mem_ack), .mem_err(mem_err), .mem_rdata(mem_rdata)
    );

    // Second instance: forwarded IACK and the shortest non-zero timeout
    m68k_bus_bridge #(.ADDR_W(24), .TIMEOUT(1), .AUTOVEC(1'b0)) dut_b (
        .clk(clk), .reset(reset), .dma_hold(dma_hold),
        .cpu_as_n(cpu_as_n), .cpu_uds_n(cpu_uds_n), .cpu_lds_n(cpu_lds_n),
        .cpu_rw_n(cpu_rw_n), .cpu_fc(cpu_fc), .cpu_addr(cpu_addr), .cpu_dout(cpu_dout),
        .cpu_din(b_din), .cpu_dtack_n(b_dtack_n), .cpu_vpa_n(b_vpa_n), .cpu_berr_n(b_berr_n),
        .mem_req(b_req), .mem_we(b_we), .mem_be(b_be), .mem_addr(b_addr), .mem_wdata(b_wdata),
        .mem_ack(mem_ack), .mem_err(mem_err), .mem_rdata(mem_rdata)
    );

    // exp_kind: 0 = DTACK, 1 = BERR, 2 = VPA (autovector)
    typedef struct {
        logic [23:0] byte_addr;
        logic [15:0] wdata;
        logic        uds_n, lds_n, rw_n;
        logic [2:0]  fc;
        int          ack_at;
        logic        err;
        logic [15:0] rdata;
        int          hold_extra;
        int          exp_kind;
        int          exp_cycles;
        logic [1:0]  exp_be;
        logic        exp_we;
        logic [22:0] exp_maddr;
        logic [15:0] exp_din;
    } vec_t;

    vec_t        tbl[6];
    logic [15:0] m_din;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_idle();
        cpu_as_n = 1'b1; cpu_uds_n = 1'b1; cpu_lds_n = 1'b1; cpu_rw_n = 1'b1;
        cpu_fc = 3'd0; mem_ack = 1'b0; mem_err = 1'b0;
    endtask

    task automatic do_reset();
        bus_idle();
        dma_hold = 1'b0;
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
    endtask

    // Behavioural model: outcome of one CPU cycle from the bridge's rules
    task automatic model(inout vec_t v);
        v.exp_be    = ~{v.uds_n, v.lds_n};
        v.exp_we    = ~v.rw_n;
        v.exp_maddr = v.byte_addr[23:1];
        if (v.fc == 3'b111) begin
            v.exp_kind   = 2;
            v.exp_cycles = 0;
        end else if (v.ack_at < TO_A) begin
            v.exp_cycles = v.ack_at + 1;
            v.exp_kind   = v.err ? 1 : 0;
            if (!v.err && v.rw_n) m_din = v.rdata;
        end else begin
            v.exp_cycles = TO_A;
            v.exp_kind   = 1;
        end
        v.exp_din = m_din;
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int n;
        cpu_addr = v.byte_addr[23:1]; cpu_dout = v.wdata;
        cpu_uds_n = v.uds_n; cpu_lds_n = v.lds_n; cpu_rw_n = v.rw_n; cpu_fc = v.fc;
        cpu_as_n = 1'b0;
        tick();
        if (v.exp_kind == 2) begin
            chk({tag, " iack_vpa"}, 32'(a_vpa_n), 32'd0);
            chk({tag, " iack_noreq"}, 32'(a_req), 32'd0);
        end else begin
            chk({tag, " req_start"}, 32'(a_req), 32'd1);
            chk({tag, " mem_we"}, 32'(a_we), 32'(v.exp_we));
            chk({tag, " mem_be"}, 32'(a_be), 32'(v.exp_be));
            chk({tag, " mem_wdata"}, 32'(a_wdata), 32'(v.wdata));
            n = 0;
            while (a_req === 1'b1 && n < 20) begin
                chk({tag, " mem_addr"}, 32'(a_addr), 32'(v.exp_maddr));
                mem_rdata = v.rdata;
                mem_ack = (n == v.ack_at);
                mem_err = v.err && (n == v.ack_at);
                tick();
                mem_ack = 1'b0; mem_err = 1'b0;
                n++;
            end
            chk({tag, " req_cycles"}, 32'(n), 32'(v.exp_cycles));
        end
        for (int k = 0; k <= v.hold_extra; k++) begin
            chk({tag, " dtack_n"}, 32'(a_dtack_n), (v.exp_kind == 0) ? 32'd0 : 32'd1);
            chk({tag, " berr_n"}, 32'(a_berr_n), (v.exp_kind == 1) ? 32'd0 : 32'd1);
            chk({tag, " vpa_n"}, 32'(a_vpa_n), (v.exp_kind == 2) ? 32'd0 : 32'd1);
            tick();
        end
        chk({tag, " cpu_din"}, 32'(a_din), 32'(v.exp_din));
        bus_idle();
        tick();
        chk({tag, " end_strobes"}, 32'({a_dtack_n, a_berr_n, a_vpa_n, a_req}), 32'b1110);
        $display("txn %s fc=%0d addr=0x%06h rw_n=%0d kind=%0d cycles=%0d din=0x%04h",
                 tag, v.fc, v.byte_addr, v.rw_n, v.exp_kind, v.exp_cycles, a_din);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t rv;
        cpu_addr = '0; cpu_dout = '0; mem_rdata = '0;
        do_reset();

        // Reset state
        chk("rst mem_req", 32'(a_req), 32'd0);
        chk("rst mem_we", 32'(a_we), 32'd0);
        chk("rst mem_be", 32'(a_be), 32'd0);
        chk("rst mem_addr", 32'(a_addr), 32'd0);
        chk("rst mem_wdata", 32'(a_wdata), 32'd0);
        chk("rst cpu_din", 32'(a_din), 32'd0);
        chk("rst strobes", 32'({a_dtack_n, a_vpa_n, a_berr_n}), 32'b111);
        chk("rst b strobes", 32'({b_dtack_n, b_vpa_n, b_berr_n, b_req}), 32'b1110);

        // addr, data, uds, lds, rw, fc, ack_at, err, rdata, hold, kind, cycles, be, we, maddr, din
        tbl[0] = '{24'h00FC00, 16'h0000, 1'b0, 1'b0, 1'b1, 3'd5, 2,   1'b0, 16'h1234, 1, 0, 3, 2'b11, 1'b0, 23'h007E00, 16'h1234};
        tbl[1] = '{24'hE80001, 16'hAB55, 1'b1, 1'b0, 1'b0, 3'd5, 0,   1'b0, 16'hFFFF, 0, 0, 1, 2'b01, 1'b1, 23'h740000, 16'h1234};
        tbl[2] = '{24'h000100, 16'h0000, 1'b0, 1'b1, 1'b1, 3'd6, 100, 1'b0, 16'h9999, 2, 1, 8, 2'b10, 1'b0, 23'h000080, 16'h1234};
        tbl[3] = '{24'hFFFFF0, 16'h0000, 1'b0, 1'b0, 1'b1, 3'd7, 0,   1'b0, 16'h4444, 1, 2, 0, 2'b11, 1'b0, 23'h7FFFF8, 16'h1234};
        tbl[4] = '{24'h123456, 16'hC0DE, 1'b0, 1'b0, 1'b0, 3'd1, 1,   1'b1, 16'h5555, 0, 1, 2, 2'b11, 1'b1, 23'h091A2B, 16'h1234};
        tbl[5] = '{24'hFFFFFE, 16'h0000, 1'b0, 1'b1, 1'b1, 3'd2, 7,   1'b0, 16'hBEEF, 0, 0, 8, 2'b10, 1'b0, 23'h7FFFFF, 16'hBEEF};
        for (int i = 0; i < 6; i++) begin
            run_vec(tbl[i], $sformatf("tbl%0d", i));
        end

        // dma_hold blocks the start until released
        do_reset();
        dma_hold = 1'b1;
        cpu_addr = 23'h000010; cpu_uds_n = 1'b0; cpu_lds_n = 1'b0; cpu_rw_n = 1'b1; cpu_fc = 3'd5;
        cpu_as_n = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("hold no_req", 32'(a_req), 32'd0);
        end
        dma_hold = 1'b0;
        tick();
        chk("hold release_req", 32'(a_req), 32'd1);
        mem_rdata = 16'h0F0F; mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        chk("hold dtack_n", 32'(a_dtack_n), 32'd0);
        chk("hold cpu_din", 32'(a_din), 32'h0F0F);
        bus_idle();
        tick();
        chk("hold end_dtack_n", 32'(a_dtack_n), 32'd1);
        $display("txn dma_hold sequence done");

        // Abort mid-REQ: drain until ack, no handshake; new start blocked while draining
        do_reset();
        cpu_addr = 23'h000200; cpu_uds_n = 1'b0; cpu_lds_n = 1'b0; cpu_rw_n = 1'b1; cpu_fc = 3'd5;
        cpu_as_n = 1'b0;
        tick();
        chk("drain req_start", 32'(a_req), 32'd1);
        bus_idle();
        tick();
        chk("drain req_held0", 32'(a_req), 32'd1);
        cpu_as_n = 1'b0; cpu_uds_n = 1'b0; cpu_lds_n = 1'b0;
        for (int k = 1; k < 4; k++) begin
            tick();
            chk("drain req_held", 32'(a_req), 32'd1);
            chk("drain no_dtack", 32'(a_dtack_n), 32'd1);
            chk("drain addr_kept", 32'(a_addr), 32'h000200);
        end
        mem_rdata = 16'hDEAD; mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        chk("drain req_drop", 32'(a_req), 32'd0);
        chk("drain strobes", 32'({a_dtack_n, a_berr_n, a_vpa_n}), 32'b111);
        chk("drain din_discard", 32'(a_din), 32'd0);
        tick();
        chk("drain next_start", 32'(a_req), 32'd1);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        chk("drain next_dtack", 32'(a_dtack_n), 32'd0);
        bus_idle();
        tick();
        $display("txn drain sequence done");

        // Reset while in DONE, then a late ack is ignored
        do_reset();
        cpu_addr = 23'h000300; cpu_uds_n = 1'b0; cpu_lds_n = 1'b0; cpu_rw_n = 1'b1; cpu_fc = 3'd5;
        cpu_as_n = 1'b0;
        tick();
        mem_rdata = 16'h7777; mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        chk("rdone dtack_n", 32'(a_dtack_n), 32'd0);
        reset = 1'b1; cpu_as_n = 1'b1;
        tick();
        chk("rdone dtack_n_rst", 32'(a_dtack_n), 32'd1);
        chk("rdone din_rst", 32'(a_din), 32'd0);
        chk("rdone fields_rst", 32'({a_req, a_we, a_be, a_addr}), 32'd0);
        reset = 1'b0; mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        chk("rdone late_ack_req", 32'(a_req), 32'd0);
        chk("rdone late_ack_strobes", 32'({a_dtack_n, a_berr_n, a_vpa_n}), 32'b111);
        chk("rdone late_ack_din", 32'(a_din), 32'd0);
        $display("txn reset-in-DONE sequence done");

        // IACK forwarded as a read when autovectoring is off
        do_reset();
        cpu_addr = 23'h7FFFFF; cpu_uds_n = 1'b0; cpu_lds_n = 1'b0; cpu_rw_n = 1'b1; cpu_fc = 3'b111;
        cpu_as_n = 1'b0;
        tick();
        chk("iack0 b_req", 32'(b_req), 32'd1);
        chk("iack0 b_vpa_n", 32'(b_vpa_n), 32'd1);
        chk("iack1 a_vpa_n", 32'(a_vpa_n), 32'd0);
        chk("iack1 a_req", 32'(a_req), 32'd0);
        mem_rdata = 16'h5A5A; mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        chk("iack0 b_dtack_n", 32'(b_dtack_n), 32'd0);
        chk("iack0 b_din", 32'(b_din), 32'h5A5A);
        chk("iack1 a_one_strobe", 32'({a_dtack_n, a_berr_n, a_vpa_n}), 32'b110);
        bus_idle();
        tick();
        chk("iack end_b", 32'(b_dtack_n), 32'd1);
        chk("iack end_a", 32'(a_vpa_n), 32'd1);
        $display("txn iack forward/autovector sequence done");

        // TIMEOUT=1: bus error after the very first REQ cycle
        do_reset();
        cpu_addr = 23'h000400; cpu_uds_n = 1'b1; cpu_lds_n = 1'b0; cpu_rw_n = 1'b1; cpu_fc = 3'd5;
        cpu_as_n = 1'b0;
        tick();
        chk("to1 b_req", 32'(b_req), 32'd1);
        tick();
        chk("to1 b_req_drop", 32'(b_req), 32'd0);
        chk("to1 b_strobes", 32'({b_dtack_n, b_berr_n, b_vpa_n}), 32'b101);
        bus_idle();
        tick();
        chk("to1 b_berr_end", 32'(b_berr_n), 32'd1);
        $display("txn timeout=1 sequence done");

        // Randomised transactions against the model
        do_reset();
        m_din = 16'h0000;
        for (int i = 0; i < 40; i++) begin
            int s;
            rv.byte_addr  = 24'($urandom);
            rv.wdata      = 16'($urandom);
            s             = $urandom_range(0, 2);
            rv.uds_n      = (s == 2);
            rv.lds_n      = (s == 1);
            rv.rw_n       = 1'($urandom_range(0, 1));
            rv.fc         = 3'($urandom_range(0, 7));
            rv.ack_at     = $urandom_range(0, 11);
            rv.err        = ($urandom_range(0, 5) == 0);
            rv.rdata      = 16'($urandom);
            rv.hold_extra = $urandom_range(0, 2);
            rv.exp_kind = 0; rv.exp_cycles = 0; rv.exp_be = '0; rv.exp_we = 1'b0;
            rv.exp_maddr = '0; rv.exp_din = '0;
            model(rv);
            run_vec(rv, $sformatf("rnd%0d", i));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/m68k_bus_bridge.md
Name: m68k_bus_bridge

Overview:
- Converts the asynchronous-style 68000 bus into a synchronous single-outstanding request/acknowledge memory port, sampled in the system clock domain.
- Shared by all CPU cores behind the CPU selector, and sits between the CPU mux output and the address decoder / SDRAM arbiter.
- Adds behaviour the plain wrapper lacks: parametrised address width, autovectored interrupt-acknowledge, bus-error timeout, DMA hold-off, and abort/drain handling.

Parameters:
- ADDR_W, 24: CPU byte-address width; the bus carries bits ADDR_W-1:1.
- TIMEOUT, 255: clk cycles in REQ before bus error is signalled; 0 disables the timeout.
- AUTOVEC, 1: 1 answers IACK cycles (fc==3'b111) locally with VPA; 0 forwards them to memory like a normal read.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- dma_hold  in  1  high blocks new cycle starts; a cycle already in progress completes
- cpu_as_n  in  1  address strobe
- cpu_uds_n  in  1  upper data strobe
- cpu_lds_n  in  1  lower data strobe
- cpu_rw_n  in  1  1 = read
- cpu_fc  in  3  function code
- cpu_addr  in  ADDR_W-1  word address (bits ADDR_W-1:1)
- cpu_dout  in  16  write data from CPU
- cpu_din  out  16  read data to CPU
- cpu_dtack_n  out  1  data acknowledge
- cpu_vpa_n  out  1  valid peripheral address (autovector)
- cpu_berr_n  out  1  bus error
- mem_req  out  1  request, level
- mem_we  out  1  write
- mem_be  out  2  byte enables {upper, lower}
- mem_addr  out  ADDR_W-1  word address
- mem_wdata  out  16  write data
- mem_ack  in  1  one-cycle completion pulse
- mem_err  in  1  one-cycle error completion (takes priority over mem_ack)
- mem_rdata  in  16  read data, valid when mem_ack=1

Behaviour:
- Reset state: IDLE. Outputs: mem_req=0, mem_we=0, mem_be=0, mem_addr=0, mem_wdata=0, cpu_din=0, cpu_dtack_n=1, cpu_vpa_n=1, cpu_berr_n=1. Timeout counter=0. Reset mid-cycle drops every handshake output in the same edge; an ack arriving after reset is ignored.
- Start condition (IDLE only): cpu_as_n=0, at least one data strobe low, dma_hold=0.
- IDLE -> IACK: start with fc==3'b111 and AUTOVEC=1. cpu_vpa_n=0 from the next cycle.
- IDLE -> REQ: any other start. On the same edge, latch mem_addr=cpu_addr, mem_we=~cpu_rw_n, mem_be=~{uds_n,lds_n}, mem_wdata=cpu_dout. Set mem_req=1 and clear the counter.
- REQ: mem_req is held at 1 with stable fields.
  - mem_err: mem_req=0, go to BERR.
  - else mem_ack: mem_req=0, cpu_din=mem_rdata (reads only; writes leave cpu_din unchanged), go to DONE.
  - else cpu_as_n=1 (abort): go to DRAIN.
  - else TIMEOUT!=0 and counter==TIMEOUT-1: mem_req=0, go to BERR.
  - otherwise the counter increments.
- DONE: cpu_dtack_n=0, so DTACK is first low 1 clk after the ack edge. Held until cpu_as_n is sampled 1, then cpu_dtack_n=1 and go to IDLE.
- BERR: cpu_berr_n=0 until cpu_as_n=1, then cpu_berr_n=1 and go to IDLE. DTACK is never asserted for that cycle.
- IACK: cpu_vpa_n=0 until cpu_as_n=1, then cpu_vpa_n=1 and go to IDLE.
- DRAIN: mem_req stays 1 until mem_ack or mem_err, then mem_req=0 and go to IDLE. Data is discarded and no CPU handshake is given. A new start is not accepted in DRAIN.
- A new cycle is never accepted in the same clk that the previous one returns to IDLE. There is at least one IDLE cycle between bus cycles.
- Never more than one of dtack_n/vpa_n/berr_n is low at a time.
- dma_hold is sampled only in IDLE.
- Counter width is clog2(TIMEOUT+1). TIMEOUT=1 gives BERR on the first REQ cycle with no ack.

Test Plan:
- Word read at 0x00FC00: AS/UDS/LDS low, rw_n=1; mem_ack with rdata=0x1234 on the 3rd REQ cycle -> mem_be=2'b11, mem_addr=0x7E00, cpu_din=0x1234, dtack_n low 1 clk after the ack and held until AS high, then IDLE.
- Byte write of 0xAB55 to 0xE80001 (LDS only): ack on the 1st cycle -> mem_we=1, mem_be=2'b01, mem_wdata=0xAB55, cpu_din unchanged.
- TIMEOUT=8 with no mem_ack -> mem_req drops after exactly 8 REQ cycles; berr_n=0 until AS high; dtack_n stays 1.
- IACK: fc=3'b111 with AUTOVEC=1 -> vpa_n=0 next cycle and mem_req never rises. Same stimulus with AUTOVEC=0 -> normal mem read.
- dma_hold=1 while AS falls -> no mem_req. Release dma_hold -> mem_req 1 clk later. Also: AS high mid-REQ then ack 4 cycles later -> DRAIN; mem_req held until the ack, no dtack.
- reset asserted in DONE -> all outputs return to reset values on the next edge; a following ack pulse is ignored.
